tuple_sink: RTL and testbench
=============================

# tuple_sink

Consumer end of the triplet result stream produced by the zero-sum search engine. It accepts one (tuple1, tuple2, tuple3) triplet per valid/ack handshake and checks that the three signed bytes sum exactly to zero. Each triplet and its check flag go into a show-ahead FIFO, which the downstream logic or bench drains. The block also keeps saturating counts of accepted and failing tuples.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256
- CNT_W, 8, width of the tuple and error counters

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-low
- clr  in  1  synchronous clear: empties FIFO, zeroes counters, returns FSM to IDLE
- valid  in  1  producer tuple valid; level, held until ack
- tuple1  in  8  first element, two's complement
- tuple2  in  8  second element
- tuple3  in  8  third element
- ack  out  1  one-cycle acknowledge pulse, registered
- rd_en  in  1  pop head entry
- rd_data  out  25  head entry {bad, tuple1, tuple2, tuple3}; valid only when !empty
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- tuple_cnt  out  CNT_W  tuples accepted since reset/clr, saturating
- err_cnt  out  CNT_W  accepted tuples with nonzero sum, saturating

## Operation
- FSM states: IDLE, ACK, WAIT_LOW.
  - IDLE: if valid && !full, write {bad, tuple1, tuple2, tuple3} to FIFO, increment counters, go to ACK.
  - IDLE with valid && full: stay in IDLE and do not ack. This back-pressures the producer.
  - ACK: ack=1 for exactly this state; go to WAIT_LOW unconditionally.
  - WAIT_LOW: stay until valid is sampled 0, then go to IDLE. This prevents a held valid from being double-captured.
- Sum check:
  - Sign-extend each input to 10 bits and add.
  - bad = (sum != 0). No modulo-256 wrap: (0x80, 0x80, 0x00) gives bad=1.
- Counters: tuple_cnt += 1 on every capture; err_cnt += 1 when bad. Both stick at all-ones.
- FIFO:
  - Show-ahead: rd_data is the head entry combinationally.
  - rd_en while empty is ignored; no pointer movement.
  - A push and a pop in the same cycle are both performed; count unchanged.
  - full is evaluated before the pop. A full FIFO with rd_en high still refuses the capture that cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally. A separate occupancy counter of log2(DEPTH)+1 bits drives full and empty.
- clr takes priority over capture and pop in the same cycle. Any ack already in flight still completes its pulse.

## Timing
- Reset values: ack=0, empty=1, full=0, tuple_cnt=0, err_cnt=0, FSM=IDLE, pointers=0. rd_data is don't-care.
- Reset mid-handshake aborts it: ack drops immediately, and any entry being written that cycle is discarded.
- Capture latency:
  - valid is sampled high at edge N while in IDLE and not full.
  - The entry is visible on rd_data and empty=0 after edge N.
  - ack is high from edge N to edge N+1.
- The producer drops valid in response to ack. The sink leaves WAIT_LOW on the first edge at which valid=0.
- Maximum throughput is one tuple per 3 cycles.
- Pop: rd_en at edge M removes the head; the next entry (or empty=1) is visible after edge M.
- Counters update at the capture edge N.

## Structure
- Package tuple_pkg:
  - TUPLE_W=8
  - ENTRY_W=3*TUPLE_W+1
  - state enum {IDLE, ACK, WAIT_LOW}
  - function zero_sum_bad(t1, t2, t3) implementing the 10-bit signed check
- Sub-module tuple_fifo holds DEPTH x ENTRY_W storage, pointers, occupancy, full and empty.
- The tuple_sink top holds the FSM, the sum check and the counters.

## Test plan
- Single good tuple: (0x05, 0xFD, 0xFE), valid held until ack → one ack pulse, rd_data=0_05_FD_FE, tuple_cnt=1, err_cnt=0.
- Bad and wrap tuples:
  - (0x01, 0x01, 0x01) → bad=1, err_cnt=1.
  - (0x80, 0x80, 0x00) → bad=1 (no mod-256 acceptance).
- Held valid: valid kept high 10 cycles after ack → exactly one capture and one ack; tuple_cnt=1.
- Full back-pressure:
  - DEPTH=16; push 16 tuples with no reads → full=1.
  - 17th valid gets no ack until one rd_en. It is then captured and acked, and FIFO order is preserved on drain.
- Simultaneous push/pop at occupancy 5, plus rd_en while empty → occupancy stays 5; the empty pop leaves pointers and empty=1 unchanged.
- Reset and clr:
  - reset asserted low during the ACK state → ack=0 immediately and all outputs at reset values.
  - clr with 3 entries and counters at 3/1 → empty=1, counters 0.
  - tuple_cnt saturates at 255 after 300 tuples.

Source files
------------

// File: rtl/tuple_pkg.sv
// tuple_pkg: shared widths, FSM state type and the zero-sum check for the tuple sink
`timescale 1ns/1ps
package tuple_pkg;
   localparam int TUPLE_W = 8;
   localparam int ENTRY_W = 3*TUPLE_W + 1;
   typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
   // Two guard bits hold the full signed range, so 0x80+0x80+0x00 does not alias to zero
   function automatic logic zero_sum_bad(input logic [TUPLE_W-1:0] t1, input logic [TUPLE_W-1:0] t2,
                                         input logic [TUPLE_W-1:0] t3);
      logic [TUPLE_W+1:0] s;
      s = {{2{t1[TUPLE_W-1]}}, t1} + {{2{t2[TUPLE_W-1]}}, t2} + {{2{t3[TUPLE_W-1]}}, t3};
      return s != '0;
   endfunction
endpackage

// File: rtl/tuple_fifo.sv
// tuple_fifo: show-ahead FIFO with wrapping pointers and a separate occupancy count
`timescale 1ns/1ps
module tuple_fifo
   import tuple_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               push,
   input  logic               pop,
   input  logic [ENTRY_W-1:0] wr_data,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               empty,
   output logic               full
);
   localparam int AW = $clog2(DEPTH);
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [AW-1:0]      wp, rp;
   logic [AW:0]        cnt;
   logic               do_push, do_pop;
   assign empty   = cnt == '0;
   assign full    = cnt == (AW+1)'(DEPTH);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rp];
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (clr) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop) rp <= rp + AW'(1);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push && !clr) mem[wp] <= wr_data;
endmodule

// File: rtl/tuple_sink.sv
// tuple_sink: valid/ack triplet consumer with zero-sum check, result FIFO and saturating counters
`timescale 1ns/1ps
module tuple_sink
   import tuple_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               valid,
   input  logic [TUPLE_W-1:0] tuple1,
   input  logic [TUPLE_W-1:0] tuple2,
   input  logic [TUPLE_W-1:0] tuple3,
   output logic               ack,
   input  logic               rd_en,
   output logic [ENTRY_W-1:0] rd_data,
   output logic               empty,
   output logic               full,
   output logic [CNT_W-1:0]   tuple_cnt,
   output logic [CNT_W-1:0]   err_cnt
);
   state_t state;
   logic   bad, capture;
   assign bad     = zero_sum_bad(tuple1, tuple2, tuple3);
   assign capture = state == IDLE && valid && !full && !clr;
   tuple_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .push    (capture),
      .pop     (rd_en),
      .wr_data ({bad, tuple1, tuple2, tuple3}),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (full)
   );
   // WAIT_LOW holds off until the producer drops valid, so a held valid is captured once
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         ack       <= 1'b0;
         tuple_cnt <= '0;
         err_cnt   <= '0;
      end else if (clr) begin
         state     <= IDLE;
         ack       <= 1'b0;
         tuple_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         state <= state == IDLE ? (capture ? ACK : IDLE) :
                  state == ACK  ? WAIT_LOW :
                  valid         ? WAIT_LOW : IDLE;
         ack   <= capture;
         if (capture) tuple_cnt <= tuple_cnt + CNT_W'(tuple_cnt != '1);
         if (capture && bad) err_cnt <= err_cnt + CNT_W'(err_cnt != '1);
      end
endmodule

// File: tb/tb_tuple_sink.sv
// tb_tuple_sink: directed stimulus with an expected-entry queue checked by a FIFO-pop monitor
`timescale 1ns/1ps
module tb_tuple_sink;
   logic        clk = 0, reset = 0, clr = 0, valid = 0, rd_en = 0;
   logic [7:0]  t1 = 0, t2 = 0, t3 = 0;
   logic        ack, empty, full;
   logic [24:0] rd_data;
   logic [7:0]  tuple_cnt, err_cnt;
   int          checks = 0, passes = 0, acks = 0, pops = 0;
   logic [24:0] exp_q[$];

   always #5 clk = ~clk;

   tuple_sink #(.DEPTH(16), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .clr(clr), .valid(valid),
      .tuple1(t1), .tuple2(t2), .tuple3(t3), .ack(ack),
      .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
      .tuple_cnt(tuple_cnt), .err_cnt(err_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every real pop is compared against the oldest expected entry
   always @(negedge clk)
      if (reset) begin
         if (ack) acks++;
         if (rd_en && !empty && !clr) begin
            pops++;
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL pop_unexpected: got %0h expected no entry", rd_data);
            end else check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
         end
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic bad, input int hold = 0);
      int n = 0;
      t1 = a; t2 = b; t3 = c;
      exp_q.push_back({bad, a, b, c});
      valid = 1;
      do begin
         tick();
         n++;
      end while (!ack && n < 200);
      if (!ack) begin
         checks++;
         $display("FAIL ack_timeout: got no ack expected ack for %h_%h_%h", a, b, c);
      end
      repeat (hold) tick();
      valid = 0;
      tick();
      tick();
   endtask

   task automatic drain();
      int n = 0;
      rd_en = 1;
      while (!empty && n < 400) begin
         tick();
         n++;
      end
      rd_en = 0;
   endtask

   task automatic do_clr();
      clr = 1;
      tick();
      clr = 0;
      exp_q.delete();
   endtask

   initial begin
      int a0, p0;
      repeat (3) tick();
      check("rst_ack", ack, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_tuple_cnt", tuple_cnt, 0);
      check("rst_err_cnt", err_cnt, 0);
      reset = 1;
      tick();
      // single good tuple
      send(8'h05, 8'hFD, 8'hFE, 0);
      check("good_acks", acks, 1);
      check("good_rd_data", rd_data, 25'h0_05FDFE);
      check("good_tuple_cnt", tuple_cnt, 1);
      check("good_err_cnt", err_cnt, 0);
      // bad and wrap cases
      send(8'h01, 8'h01, 8'h01, 1);
      check("bad_err_cnt", err_cnt, 1);
      send(8'h80, 8'h80, 8'h00, 1);
      check("wrap_err_cnt", err_cnt, 2);
      send(8'h7F, 8'h81, 8'h00, 0);
      send(8'h80, 8'h7F, 8'h01, 0);
      check("mix_tuple_cnt", tuple_cnt, 5);
      check("mix_err_cnt", err_cnt, 2);
      p0 = pops;
      drain();
      check("mix_drained", pops - p0, 5);
      // held valid
      do_clr();
      a0 = acks;
      send(8'h11, 8'h22, 8'hCD, 0, 10);
      check("held_acks", acks - a0, 1);
      check("held_tuple_cnt", tuple_cnt, 1);
      drain();
      // full back-pressure
      do_clr();
      for (int i = 0; i < 16; i++) send(8'(i), 8'(-i), {7'd0, 1'(i)}, 1'(i));
      check("full_flag", full, 1);
      check("full_tuple_cnt", tuple_cnt, 16);
      check("full_err_cnt", err_cnt, 8);
      a0 = acks;
      t1 = 8'h40; t2 = 8'hC0; t3 = 8'h00;
      valid = 1;
      repeat (5) tick();
      check("full_no_ack", acks - a0, 0);
      rd_en = 1;
      tick();
      rd_en = 0;
      check("full_pop_no_capture", ack, 0);
      send(8'h40, 8'hC0, 8'h00, 0);
      check("full_late_ack", acks - a0, 1);
      check("full_again", full, 1);
      p0 = pops;
      drain();
      check("full_drained", pops - p0, 16);
      // simultaneous push and pop at occupancy 5
      do_clr();
      for (int i = 1; i <= 5; i++) send(8'(i), 8'(i), 8'(-2*i), 0);
      t1 = 8'h33; t2 = 8'hCD; t3 = 8'h00;
      valid = 1;
      rd_en = 1;
      tick();
      rd_en = 0;
      exp_q.push_back(25'h0_33CD00);
      check("simul_ack", ack, 1);
      valid = 0;
      tick();
      tick();
      p0 = pops;
      drain();
      check("simul_occupancy", pops - p0, 5);
      p0 = pops;
      rd_en = 1;
      repeat (3) tick();
      rd_en = 0;
      check("empty_pop_empty", empty, 1);
      check("empty_pop_none", pops - p0, 0);
      send(8'h0A, 8'h0B, 8'hEB, 0);
      check("after_empty_pop", rd_data, 25'h0_0A0BEB);
      drain();
      // clr with counters 3/1
      do_clr();
      send(8'h01, 8'hFF, 8'h00, 0);
      send(8'h02, 8'h02, 8'h02, 1);
      send(8'hF0, 8'h08, 8'h08, 0);
      check("pre_clr_tuple_cnt", tuple_cnt, 3);
      check("pre_clr_err_cnt", err_cnt, 1);
      do_clr();
      check("clr_empty", empty, 1);
      check("clr_tuple_cnt", tuple_cnt, 0);
      check("clr_err_cnt", err_cnt, 0);
      // saturation over 300 tuples, draining continuously
      rd_en = 1;
      for (int i = 0; i < 300; i++) send(8'h01, 8'h01, 8'h01, 1);
      tick();
      rd_en = 0;
      check("sat_tuple_cnt", tuple_cnt, 255);
      check("sat_err_cnt", err_cnt, 255);
      check("sat_queue_empty", exp_q.size(), 0);
      // reset during ACK
      t1 = 8'h05; t2 = 8'hFD; t3 = 8'hFE;
      valid = 1;
      for (int n = 0; n < 20 && !ack; n++) tick();
      check("abort_saw_ack", ack, 1);
      reset = 0;
      #1;
      check("abort_ack", ack, 0);
      check("abort_empty", empty, 1);
      check("abort_full", full, 0);
      check("abort_tuple_cnt", tuple_cnt, 0);
      check("abort_err_cnt", err_cnt, 0);
      valid = 0;
      tick();
      reset = 1;
      tick();
      check("final_queue", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end
endmodule
